// File: rtl/mask_ctrl_pkg.sv
// Shared types and constants for the frame-mask ping-pong controller.
package mask_ctrl_pkg;

  // Load FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    PEND  = 2'd3
  } state_e;

  localparam int                 BRIGHT_W   = 4;
  localparam logic [BRIGHT_W-1:0] BRIGHT_MAX = 4'd8;

  // Clamp a requested brightness to the datapath's legal range 0..BRIGHT_MAX.
  function automatic logic [BRIGHT_W-1:0] sat_bright(input logic [BRIGHT_W-1:0] v);
    return (v > BRIGHT_MAX) ? BRIGHT_MAX : v;
  endfunction

endpackage

// File: rtl/mask_wr_port.sv
// Registered write-port driver for one mask BRAM: converts a write request
// (bank, word index, data) into enable/strobe/byte-address/data one cycle later.
// Idle cycles drive enable, strobe, address and data to zero.
module mask_wr_port
  import mask_ctrl_pkg::*;
#(
  parameter int WORDS      = 153600,
  parameter int BANK_BYTES = WORDS * 4,
  parameter int IDX_W      = $clog2(WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             bank,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      data,
  output logic             en,
  output logic             we,
  output logic [31:0]      addr,
  output logic [31:0]      din
);

  localparam logic [31:0] BANK_OFS = 32'(BANK_BYTES);

  logic [31:0] byte_ofs;
  logic        en_q;
  logic [31:0] addr_q, din_q;

  // Word index to byte offset within the bank.
  always_comb begin
    byte_ofs = {{(32 - IDX_W - 2){1'b0}}, idx, 2'b00};
  end

  // Register the write beat; anything other than a request clears the port.
  // NOTE: non-blocking assignments so every register here samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
    end else if (req) begin
      en_q   <= 1'b1;
      addr_q <= (bank ? BANK_OFS : 32'd0) + byte_ofs;
      din_q  <= data;
    end else begin
      en_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
    end
  end

  assign en   = en_q;
  assign we   = en_q;
  assign addr = addr_q;
  assign din  = din_q;

endmodule

// File: rtl/mask_bank_ctrl.sv
// Ping-pong controller for the two frame-mask BRAMs. Loads a mask image from
// the 32-bit load stream into the inactive bank of the selected mask, then at
// the next start-of-frame swaps that mask's read bank and applies pending
// brightness, so no frame mixes old and new settings.
// Optional: define MASK_CTRL_FRAME_CNT_EN to add frame_cnt and swap_cnt outputs.
module mask_bank_ctrl
  import mask_ctrl_pkg::*;
#(
  parameter int WORDS      = 153600,
  parameter int BANK_BYTES = WORDS * 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sof,
  input  logic [31:0]         l_s_tdata,
  input  logic                l_s_tvalid,
  output logic                l_s_tready,
  input  logic                l_s_tlast,
  input  logic                l_s_tdest,
  output logic                wr_en0,
  output logic                wr_we0,
  output logic [31:0]         wr_addr0,
  output logic [31:0]         wr_din0,
  output logic                wr_en1,
  output logic                wr_we1,
  output logic [31:0]         wr_addr1,
  output logic [31:0]         wr_din1,
  output logic                rd_bank0,
  output logic                rd_bank1,
  input  logic [BRIGHT_W-1:0] cfg_bright0,
  input  logic [BRIGHT_W-1:0] cfg_bright1,
  input  logic                cfg_wr,
  output logic [BRIGHT_W-1:0] bright_val0,
  output logic [BRIGHT_W-1:0] bright_val1,
  output logic                swap_pend,
  output logic                err_short,
  output logic                err_long
`ifdef MASK_CTRL_FRAME_CNT_EN
  ,
  output logic [15:0]         frame_cnt,
  output logic [15:0]         swap_cnt
`endif
);

  localparam int               IDX_W    = $clog2(WORDS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               tgt_q, tgt_d;
  logic [1:0]         rd_bank_q;
  logic               err_short_q, err_short_d;
  logic               err_long_q, err_long_d;
  logic [BRIGHT_W-1:0] pend0_q, pend1_q, bright0_q, bright1_q;

  logic               accept;
  logic               wr_req, swap;
  logic [IDX_W-1:0]   widx;
  logic               wtgt;

  assign accept = l_s_tvalid & l_s_tready;
  // The first beat of an image is word 0 and carries the target mask.
  assign widx   = (state_q == IDLE) ? '0 : idx_q;
  assign wtgt   = (state_q == IDLE) ? l_s_tdest : tgt_q;

  // State register and load bookkeeping.
  // NOTE: reset clears control state only; BRAM contents are never cleared,
  // so an abandoned load leaves the inactive bank undefined.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      tgt_q       <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tgt_q       <= tgt_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
    end
  end

  // Next-state logic: beat accounting, error detection and swap request.
  // NOTE: every signal gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tgt_d       = tgt_q;
    wr_req      = 1'b0;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    swap        = 1'b0;
    unique case (state_q)
      IDLE, LOAD: begin
        if (accept) begin
          wr_req = 1'b1;
          tgt_d  = wtgt;
          idx_d  = widx + IDX_W'(1);
          if (l_s_tlast) begin
            idx_d = '0;
            if (widx == LAST_IDX) begin
              state_d = PEND;
            end else begin
              err_short_d = 1'b1;
              state_d     = IDLE;
            end
          end else if (widx == LAST_IDX) begin
            idx_d   = '0;
            state_d = DRAIN;
          end else begin
            state_d = LOAD;
          end
        end
      end
      DRAIN: begin
        if (accept && l_s_tlast) begin
          err_long_d = 1'b1;
          state_d    = PEND;
        end
      end
      PEND: begin
        if (sof) begin
          swap    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stream handshake and status depend on state only, never on tvalid.
  always_comb begin
    l_s_tready = !rst && (state_q != PEND);
    swap_pend  = (state_q == PEND);
  end

  // Read-bank selection toggles for the loaded mask at the swapping sof.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_bank_q <= 2'b00;
    end else if (swap) begin
      rd_bank_q[tgt_q] <= ~rd_bank_q[tgt_q];
    end
  end

  // Brightness: capture saturated requests, apply them at start-of-frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend0_q   <= BRIGHT_MAX;
      pend1_q   <= BRIGHT_MAX;
      bright0_q <= BRIGHT_MAX;
      bright1_q <= BRIGHT_MAX;
    end else begin
      if (cfg_wr) begin
        pend0_q <= sat_bright(cfg_bright0);
        pend1_q <= sat_bright(cfg_bright1);
      end
      if (sof) begin
        bright0_q <= pend0_q;
        bright1_q <= pend1_q;
      end
    end
  end

  mask_wr_port #(
    .WORDS      (WORDS),
    .BANK_BYTES (BANK_BYTES),
    .IDX_W      (IDX_W)
  ) u_wr_port0 (
    .clk  (clk),
    .rst  (rst),
    .req  (wr_req && !wtgt),
    .bank (~rd_bank_q[0]),
    .idx  (widx),
    .data (l_s_tdata),
    .en   (wr_en0),
    .we   (wr_we0),
    .addr (wr_addr0),
    .din  (wr_din0)
  );

  mask_wr_port #(
    .WORDS      (WORDS),
    .BANK_BYTES (BANK_BYTES),
    .IDX_W      (IDX_W)
  ) u_wr_port1 (
    .clk  (clk),
    .rst  (rst),
    .req  (wr_req && wtgt),
    .bank (~rd_bank_q[1]),
    .idx  (widx),
    .data (l_s_tdata),
    .en   (wr_en1),
    .we   (wr_we1),
    .addr (wr_addr1),
    .din  (wr_din1)
  );

  assign rd_bank0    = rd_bank_q[0];
  assign rd_bank1    = rd_bank_q[1];
  assign bright_val0 = bright0_q;
  assign bright_val1 = bright1_q;
  assign err_short   = err_short_q;
  assign err_long    = err_long_q;

`ifdef MASK_CTRL_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, swap_cnt_q;

  // Free-running frame and swap counters, wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      swap_cnt_q  <= '0;
    end else begin
      if (sof)  frame_cnt_q <= frame_cnt_q + 16'd1;
      if (swap) swap_cnt_q  <= swap_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign swap_cnt  = swap_cnt_q;
`endif

endmodule

// File: tb/tb_mask_bank_ctrl.sv
// Directed bench for mask_bank_ctrl with a 16-word mask bank.
module tb_mask_bank_ctrl;

  localparam int WORDS      = 16;
  localparam int BANK_BYTES = WORDS * 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        sof;
  logic [31:0] l_s_tdata;
  logic        l_s_tvalid, l_s_tready, l_s_tlast, l_s_tdest;
  logic        wr_en0, wr_we0, wr_en1, wr_we1;
  logic [31:0] wr_addr0, wr_din0, wr_addr1, wr_din1;
  logic        rd_bank0, rd_bank1;
  logic [3:0]  cfg_bright0, cfg_bright1;
  logic        cfg_wr;
  logic [3:0]  bright_val0, bright_val1;
  logic        swap_pend, err_short, err_long;
`ifdef MASK_CTRL_FRAME_CNT_EN
  logic [15:0] frame_cnt, swap_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [3:0] b0;
    logic [3:0] b1;
    logic [3:0] exp0;
    logic [3:0] exp1;
  } bright_vec_t;

  bright_vec_t vecs[5];

  always #5 clk = ~clk;

  mask_bank_ctrl #(
    .WORDS      (WORDS),
    .BANK_BYTES (BANK_BYTES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sof         (sof),
    .l_s_tdata   (l_s_tdata),
    .l_s_tvalid  (l_s_tvalid),
    .l_s_tready  (l_s_tready),
    .l_s_tlast   (l_s_tlast),
    .l_s_tdest   (l_s_tdest),
    .wr_en0      (wr_en0),
    .wr_we0      (wr_we0),
    .wr_addr0    (wr_addr0),
    .wr_din0     (wr_din0),
    .wr_en1      (wr_en1),
    .wr_we1      (wr_we1),
    .wr_addr1    (wr_addr1),
    .wr_din1     (wr_din1),
    .rd_bank0    (rd_bank0),
    .rd_bank1    (rd_bank1),
    .cfg_bright0 (cfg_bright0),
    .cfg_bright1 (cfg_bright1),
    .cfg_wr      (cfg_wr),
    .bright_val0 (bright_val0),
    .bright_val1 (bright_val1),
    .swap_pend   (swap_pend),
    .err_short   (err_short),
    .err_long    (err_long)
`ifdef MASK_CTRL_FRAME_CNT_EN
    ,
    .frame_cnt   (frame_cnt),
    .swap_cnt    (swap_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // One clock: inputs are driven after the falling edge, outputs sampled there.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Stream n beats (data = index) to mask dest; tlast on the final beat and
  // optionally sof alongside it. base is the expected byte offset of the
  // inactive bank. Checks each registered write and the error pulses.
  task automatic do_load(input logic dest, input int n, input logic sof_last, input int base);
    logic exp_en, exp_es, exp_el;
    for (int i = 0; i < n; i++) begin
      l_s_tvalid = 1'b1;
      l_s_tdata  = 32'(i);
      l_s_tdest  = dest;
      l_s_tlast  = (i == n - 1);
      sof        = sof_last && (i == n - 1);
      #1;
      check("load_tready", 32'(l_s_tready), 32'd1);
      tick();
      exp_en = (i < WORDS);
      exp_es = (i == n - 1) && (n < WORDS);
      exp_el = (i == n - 1) && (n > WORDS);
      check("wr_en_tgt",   32'(dest ? wr_en1 : wr_en0), 32'(exp_en));
      check("wr_en_other", 32'(dest ? wr_en0 : wr_en1), 32'd0);
      if (exp_en) begin
        check("wr_we_tgt", 32'(dest ? wr_we1 : wr_we0), 32'd1);
        check("wr_addr",   dest ? wr_addr1 : wr_addr0, 32'(base + 4 * i));
        check("wr_din",    dest ? wr_din1 : wr_din0, 32'(i));
      end
      check("err_short", 32'(err_short), 32'(exp_es));
      check("err_long",  32'(err_long), 32'(exp_el));
    end
    l_s_tvalid = 1'b0;
    l_s_tlast  = 1'b0;
    l_s_tdata  = '0;
    sof        = 1'b0;
  endtask

  task automatic pulse_sof();
    sof = 1'b1;
    tick();
    sof = 1'b0;
  endtask

  task automatic cfg_write(input logic [3:0] b0, input logic [3:0] b1);
    cfg_bright0 = b0;
    cfg_bright1 = b1;
    cfg_wr      = 1'b1;
    tick();
    cfg_wr      = 1'b0;
  endtask

  initial begin
    logic [3:0] prev0, prev1;

    vecs[0] = '{b0: 4'd0,  b1: 4'd0,  exp0: 4'd0, exp1: 4'd0};
    vecs[1] = '{b0: 4'd8,  b1: 4'd9,  exp0: 4'd8, exp1: 4'd8};
    vecs[2] = '{b0: 4'd15, b1: 4'd7,  exp0: 4'd8, exp1: 4'd7};
    vecs[3] = '{b0: 4'd5,  b1: 4'd1,  exp0: 4'd5, exp1: 4'd1};
    vecs[4] = '{b0: 4'd2,  b1: 4'd14, exp0: 4'd2, exp1: 4'd8};

    rst = 1'b1; sof = 1'b0; l_s_tdata = '0; l_s_tvalid = 1'b0;
    l_s_tlast = 1'b0; l_s_tdest = 1'b0;
    cfg_bright0 = '0; cfg_bright1 = '0; cfg_wr = 1'b0;

    // Reset state.
    @(negedge clk);
    #1;
    check("rst_tready", 32'(l_s_tready), 32'd0);
    tick();
    tick();
    check("rst_rd_bank0", 32'(rd_bank0), 32'd0);
    check("rst_rd_bank1", 32'(rd_bank1), 32'd0);
    check("rst_bright0",  32'(bright_val0), 32'd8);
    check("rst_bright1",  32'(bright_val1), 32'd8);
    check("rst_wr_en0",   32'(wr_en0), 32'd0);
    check("rst_wr_en1",   32'(wr_en1), 32'd0);
    check("rst_wr_din0",  wr_din0, 32'd0);
    check("rst_swap_pend", 32'(swap_pend), 32'd0);
    check("rst_err_short", 32'(err_short), 32'd0);
    check("rst_err_long",  32'(err_long), 32'd0);
    rst = 1'b0;
    #1;
    check("idle_tready", 32'(l_s_tready), 32'd1);

    // Full load of mask 0 into bank 1, then swap at sof.
    do_load(1'b0, WORDS, 1'b0, BANK_BYTES);
    check("full_swap_pend", 32'(swap_pend), 32'd1);
    check("full_pend_tready", 32'(l_s_tready), 32'd0);
    check("full_pre_rd_bank0", 32'(rd_bank0), 32'd0);
    pulse_sof();
    check("full_rd_bank0", 32'(rd_bank0), 32'd1);
    check("full_rd_bank1", 32'(rd_bank1), 32'd0);
    check("full_swap_done", 32'(swap_pend), 32'd0);
    check("full_wr_idle", 32'(wr_en0), 32'd0);
    check("full_tready", 32'(l_s_tready), 32'd1);

    // Short load of mask 1: err_short once, no swap.
    do_load(1'b1, 10, 1'b0, BANK_BYTES);
    tick();
    check("short_err_once", 32'(err_short), 32'd0);
    check("short_no_pend", 32'(swap_pend), 32'd0);
    check("short_idle_tready", 32'(l_s_tready), 32'd1);
    pulse_sof();
    check("short_rd_bank1", 32'(rd_bank1), 32'd0);
    check("short_rd_bank0", 32'(rd_bank0), 32'd1);

    // Long load of mask 0 (bank 0 now inactive): 16 writes, err_long, swap.
    do_load(1'b0, 20, 1'b0, 0);
    check("long_swap_pend", 32'(swap_pend), 32'd1);
    tick();
    check("long_err_once", 32'(err_long), 32'd0);
    pulse_sof();
    check("long_rd_bank0", 32'(rd_bank0), 32'd0);
    check("long_rd_bank1", 32'(rd_bank1), 32'd0);

    // Reset at beat 5 of a load abandons it.
    for (int i = 0; i < 5; i++) begin
      l_s_tvalid = 1'b1; l_s_tdata = 32'(i); l_s_tdest = 1'b0; l_s_tlast = 1'b0;
      tick();
    end
    l_s_tdata = 32'd5;
    rst = 1'b1;
    #1;
    check("mid_rst_tready", 32'(l_s_tready), 32'd0);
    tick();
    l_s_tvalid = 1'b0;
    l_s_tdata  = '0;
    rst = 1'b0;
    #1;
    check("mid_rst_wr_en0", 32'(wr_en0), 32'd0);
    check("mid_rst_wr_addr0", wr_addr0, 32'd0);
    check("mid_rst_swap_pend", 32'(swap_pend), 32'd0);
    check("mid_rst_rd_bank0", 32'(rd_bank0), 32'd0);
    check("mid_rst_rd_bank1", 32'(rd_bank1), 32'd0);
    check("mid_rst_tready_idle", 32'(l_s_tready), 32'd1);

    // Restarted load begins at word 0; sof with the final beat is ignored.
    do_load(1'b0, WORDS, 1'b1, BANK_BYTES);
    check("samecyc_rd_bank0", 32'(rd_bank0), 32'd0);
    check("samecyc_pend", 32'(swap_pend), 32'd1);
    tick();
    check("samecyc_tready_a", 32'(l_s_tready), 32'd0);
    tick();
    check("samecyc_tready_b", 32'(l_s_tready), 32'd0);
    check("samecyc_still_bank0", 32'(rd_bank0), 32'd0);
    pulse_sof();
    check("samecyc_swapped", 32'(rd_bank0), 32'd1);
    check("samecyc_rd_bank1", 32'(rd_bank1), 32'd0);

    // Brightness: pending values apply only at sof, later cfg_wr overwrites.
    cfg_write(4'd3, 4'd0);
    check("br_hold0_a", 32'(bright_val0), 32'd8);
    cfg_write(4'd3, 4'd12);
    check("br_hold0_b", 32'(bright_val0), 32'd8);
    check("br_hold1_b", 32'(bright_val1), 32'd8);
    pulse_sof();
    check("br_apply0", 32'(bright_val0), 32'd3);
    check("br_apply1", 32'(bright_val1), 32'd8);

    // Brightness saturation table.
    prev0 = 4'd3;
    prev1 = 4'd8;
    for (int k = 0; k < 5; k++) begin
      cfg_write(vecs[k].b0, vecs[k].b1);
      check("tbl_hold0", 32'(bright_val0), 32'(prev0));
      check("tbl_hold1", 32'(bright_val1), 32'(prev1));
      pulse_sof();
      check("tbl_apply0", 32'(bright_val0), 32'(vecs[k].exp0));
      check("tbl_apply1", 32'(bright_val1), 32'(vecs[k].exp1));
      prev0 = vecs[k].exp0;
      prev1 = vecs[k].exp1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mask_bank_ctrl.md
# mask_bank_ctrl

Ping-pong controller for the two frame-mask BRAMs read by the mask/PWM video datapath. It accepts new mask images over a 32-bit load stream and writes them into the inactive bank of the selected mask BRAM through the BRAM write port. At the next video start-of-frame it swaps that mask's read bank and applies pending brightness values, so a frame never mixes old and new masks or brightness settings.

## Interface
Parameters:
- WORDS, 153600: 32-bit words per mask bank (640x480 pixels, 2 pixels per word).
- BANK_BYTES, WORDS*4: byte offset of bank 1 within each BRAM.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- sof  in  1  start-of-frame pulse: video input tuser&tvalid&tready, first beat only.
- l_s_tdata  in  32  mask load data.
- l_s_tvalid  in  1  load beat valid.
- l_s_tready  out  1  load beat accepted.
- l_s_tlast  in  1  last word of a mask image.
- l_s_tdest  in  1  target mask (0 or 1); sampled on the first beat only.
- wr_en0/wr_en1  out  1  BRAM write-port enable for mask 0/1.
- wr_we0/wr_we1  out  1  write strobe for mask 0/1.
- wr_addr0/wr_addr1  out  32  byte address for mask 0/1.
- wr_din0/wr_din1  out  32  write data for mask 0/1.
- rd_bank0/rd_bank1  out  1  active read bank. The datapath adds rd_bankN*BANK_BYTES to its read address.
- cfg_bright0/cfg_bright1  in  4  requested brightness, 0..8.
- cfg_wr  in  1  capture both cfg_bright values as pending.
- bright_val0/bright_val1  out  4  brightness driven to the datapath.
- swap_pend  out  1  a completed load is waiting for sof.
- err_short  out  1  one-cycle pulse: tlast arrived with fewer than WORDS beats.
- err_long  out  1  one-cycle pulse: more than WORDS beats arrived before tlast.

## Operation
- State machine states are IDLE, LOAD, DRAIN and PEND.
- IDLE:
  - l_s_tready=1.
  - On the first accepted beat: latch tdest into tgt, write word 0, set idx=1, go to LOAD. If that beat also has tlast, apply the LOAD tlast rules (WORDS=1 gives PEND).
- LOAD:
  - l_s_tready=1.
  - Each accepted beat writes to BRAM tgt: wr_en=wr_we=1, wr_din=tdata, wr_addr=(~rd_bank[tgt])*BANK_BYTES + idx*4. idx increments by one per beat.
  - On the beat with idx==WORDS-1 without tlast: go to DRAIN.
  - tlast with idx+1==WORDS: go to PEND.
  - tlast with idx+1<WORDS: pulse err_short, go to IDLE. No swap occurs; partial data stays in the inactive bank.
- DRAIN:
  - l_s_tready=1. Beats are discarded and no writes occur.
  - On tlast: pulse err_long, go to PEND. The first WORDS words are kept.
- PEND:
  - l_s_tready=0, swap_pend=1.
  - On sof: rd_bank[tgt] toggles, go to IDLE.
  - A sof in the same cycle as the final write is not used; the swap waits for the following sof.
- Brightness:
  - cfg_wr captures cfg_bright into pending registers; a later cfg_wr overwrites them.
  - On sof, pending values copy to bright_val0/1.
  - Values above 8 saturate to 8 on capture.
- Unused write port: wr_en=wr_we=0 and wr_din=0 on the non-target BRAM, and on both BRAMs outside LOAD write beats.
- Reset mid-load abandons the load. No bank swap occurs and the inactive bank contents are undefined.

## Timing
- Write outputs are registered: a beat accepted at cycle n appears on wr_* at n+1.
- Load throughput is 1 word per cycle, with no bubbles while tvalid is held high.
- tready is combinational from state only, never from tvalid.
- rd_bank and bright_val change at the clock edge that samples sof. The new values are visible from cycle sof+1, which is before the datapath's second pixel read (2-cycle BRAM pipeline).
- Reset values:
  - state=IDLE, l_s_tready=0 during reset.
  - rd_bank0=rd_bank1=0.
  - bright_val0=bright_val1=8, pending=8.
  - wr_* all 0, swap_pend=0, err pulses 0, idx=0.

## Configuration
- MASK_CTRL_FRAME_CNT_EN defined: adds output frame_cnt[15:0], which increments on every sof and wraps 0xFFFF to 0; reset value 0. It also adds swap_cnt[15:0], which increments on each bank swap.
- Undefined: neither port exists and there are no counters.

## Structure
- Package mask_ctrl_pkg holds:
  - state enum (IDLE, LOAD, DRAIN, PEND);
  - BRIGHT_MAX=8;
  - BRIGHT_W=4.
- One sub-module, mask_wr_port: the registered per-BRAM write-port driver (enable, address generation, data), instantiated twice.

## Test plan
- Load tdest=0 with WORDS beats (WORDS=16 in sim, data=index), then sof -> writes land at bank-1 addresses BANK_BYTES+0..60, rd_bank0 goes 0->1 at sof+1, rd_bank1 stays 0.
- Short load of 10 beats with tlast -> err_short pulses once, no swap at the next sof, state returns to IDLE.
- Load of 20 beats with WORDS=16 -> only 16 writes, err_long at beat 20, swap on the next sof.
- Final write and sof in the same cycle -> no swap on that sof, swap on the next; l_s_tready=0 in between.
- cfg_wr with cfg_bright0=3 mid-frame, then cfg_bright1=12 -> bright_val unchanged until sof, then 3 and 8.
- rst asserted during LOAD at beat 5 -> all outputs at reset values, rd_bank unchanged, the next load starts at idx 0.
